// File: rtl/arm_pkg.sv
// Shared definitions for the fetch front end.
// Contents:
//   if_state_t       - fetch controller state encoding (FETCH, DRAIN, STALL)
//   RESET_PC_DEFAULT - default first fetch address after reset
//   BUBBLE_WORD      - instruction word presented to decode for a bubble
//   next_addr()      - modulo-2^32 address increment
package arm_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      DRAIN = 2'd1,
      STALL = 2'd2
   } if_state_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] BUBBLE_WORD      = 32'h0000_0000;

   // Address arithmetic wraps naturally at 2^32.
   function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                             input logic [31:0] step);
      next_addr = addr + step;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline output register.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   load                 - capture pc_in/instr_in and mark valid
//   clear                - insert a bubble (has priority over load)
//   pc_in, instr_in      - values to capture on load
//   pc_out, instruction  - registered values to decode
//   valid                - registered live-instruction flag
// With neither load nor clear asserted, all outputs hold.
module if_id_reg
   import arm_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        clear,
   input  logic [31:0] pc_in,
   input  logic [31:0] instr_in,
   output logic [31:0] pc_out,
   output logic [31:0] instruction,
   output logic        valid
);

   // Output register: clear beats load; pc_out is left alone on a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_out      <= 32'h0000_0000;
         instruction <= 32'h0000_0000;
         valid       <= 1'b0;
      end else if (clear) begin
         instruction <= BUBBLE_WORD;
         valid       <= 1'b0;
      end else if (load) begin
         pc_out      <= pc_in;
         instruction <= instr_in;
         valid       <= 1'b1;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing, instruction-memory handshake,
// stall parking and branch redirect.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   freeze                   - decode hazard stall, hold IF/ID outputs
//   branch_taken/branch_addr - redirect from execute
//   imem_req/imem_addr       - request to instruction memory
//   imem_ack/imem_rdata      - one-cycle response strobe and data
//   pc_out/instruction/valid - registered IF/ID outputs to decode
module if_stage
   import arm_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] instruction,
   output logic        valid
);

   if_state_t   state_r, state_s;
   logic [31:0] pc_r, pc_s;
   logic [31:0] req_addr_r, req_addr_s;
   logic [31:0] pend_buf_r, pend_buf_s;
   logic [31:0] step_addr_s;
   logic        out_load_s, out_clear_s;
   logic [31:0] out_instr_s;

   assign step_addr_s = next_addr(req_addr_r, PC_STEP);
   assign imem_addr   = req_addr_r;
   // Gated by rst so no request is presented while reset is held.
   assign imem_req    = (state_r != STALL) && !rst;

   // State, PC, request address and parked word registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= FETCH;
         pc_r       <= RESET_PC;
         req_addr_r <= RESET_PC;
         pend_buf_r <= 32'h0000_0000;
      end else begin
         state_r    <= state_s;
         pc_r       <= pc_s;
         req_addr_r <= req_addr_s;
         pend_buf_r <= pend_buf_s;
      end
   end

   // Next-state, next-PC and IF/ID control decode.
   always_comb begin
      state_s     = state_r;
      pc_s        = pc_r;
      req_addr_s  = req_addr_r;
      pend_buf_s  = pend_buf_r;
      out_load_s  = 1'b0;
      out_clear_s = 1'b0;
      out_instr_s = imem_rdata;
      case (state_r)
         FETCH: begin
            if (branch_taken) begin
               out_clear_s = 1'b1;
               pc_s        = branch_addr;
               pend_buf_s  = BUBBLE_WORD;
               if (imem_ack) begin
                  req_addr_s = branch_addr;
                  state_s    = FETCH;
               end else begin
                  // Old request must complete before the redirect is issued.
                  state_s = DRAIN;
               end
            end else if (imem_ack) begin
               if (freeze) begin
                  pend_buf_s = imem_rdata;
                  state_s    = STALL;
               end else begin
                  out_load_s = 1'b1;
                  pc_s       = step_addr_s;
                  req_addr_s = step_addr_s;
               end
            end else begin
               out_clear_s = !freeze;
            end
         end
         DRAIN: begin
            if (branch_taken) begin
               out_clear_s = 1'b1;
               pc_s        = branch_addr;
            end else begin
               out_clear_s = !freeze;
            end
            if (imem_ack) begin
               // Stale data is dropped; fetch resumes at the latest target.
               req_addr_s = branch_taken ? branch_addr : pc_r;
               state_s    = FETCH;
            end else begin
               state_s = DRAIN;
            end
         end
         STALL: begin
            if (branch_taken) begin
               out_clear_s = 1'b1;
               pc_s        = branch_addr;
               req_addr_s  = branch_addr;
               pend_buf_s  = BUBBLE_WORD;
               state_s     = FETCH;
            end else if (!freeze) begin
               out_load_s  = 1'b1;
               out_instr_s = pend_buf_r;
               pc_s        = step_addr_s;
               req_addr_s  = step_addr_s;
               state_s     = FETCH;
            end else begin
               state_s = STALL;
            end
         end
         default: begin
            state_s = FETCH;
         end
      endcase
   end

   if_id_reg u_if_id_reg (
      .clk         (clk),
      .rst         (rst),
      .load        (out_load_s),
      .clear       (out_clear_s),
      .pc_in       (step_addr_s),
      .instr_in    (out_instr_s),
      .pc_out      (pc_out),
      .instruction (instruction),
      .valid       (valid)
   );

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: table-driven zero-wait sequence followed by
// hand-written latency/drain and reset-during-drain sequences.
module tb_if_stage;

   logic        clk;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc_out;
   logic [31:0] instruction;
   logic        valid;

   int n_checks = 0;
   int n_fail   = 0;
   int lat      = 0;
   int cnt;

   if_stage dut (
      .clk          (clk),
      .rst          (rst),
      .freeze       (freeze),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .pc_out       (pc_out),
      .instruction  (instruction),
      .valid        (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: a distinct nonzero word per address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      mem_word = a ^ 32'hDEAD_0000;
   endfunction

   // Memory model: ack after lat wait cycles, request dropped on reset.
   always @(posedge clk or posedge rst) begin
      if (rst) cnt <= 0;
      else if (imem_req && !imem_ack) cnt <= cnt + 1;
      else cnt <= 0;
   end

   always_comb begin
      imem_ack   = imem_req && (cnt >= lat);
      imem_rdata = imem_ack ? mem_word(imem_addr) : 32'h0000_0000;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   typedef struct {
      logic        frz;
      logic        br;
      logic [31:0] baddr;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
   } vec_t;

   vec_t vecs[18];

   // Drive one cycle of inputs, check the request, clock, check outputs.
   task automatic step(input logic frz, input logic br, input logic [31:0] baddr,
                       input logic exp_req, input logic [31:0] exp_addr,
                       input logic exp_valid, input logic [31:0] exp_pc,
                       input logic [31:0] exp_instr, input string tag);
      freeze = frz;
      branch_taken = br;
      branch_addr = baddr;
      #1;
      check({tag, " imem_req"}, {31'd0, imem_req}, {31'd0, exp_req});
      check({tag, " imem_addr"}, imem_addr, exp_addr);
      @(posedge clk);
      #1;
      check({tag, " valid"}, {31'd0, valid}, {31'd0, exp_valid});
      check({tag, " pc_out"}, pc_out, exp_pc);
      check({tag, " instruction"}, instruction, exp_instr);
   endtask

   initial begin
      rst = 1'b1;
      freeze = 1'b0;
      branch_taken = 1'b0;
      branch_addr = 32'h0000_0000;

      //            frz   br    baddr          req   addr           val   pc_out         instr
      vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b1, 32'h0000_0004, mem_word(32'h0000_0000)};
      vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0004, 1'b1, 32'h0000_0008, mem_word(32'h0000_0004)};
      vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0008, 1'b1, 32'h0000_000C, mem_word(32'h0000_0008)};
      vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_000C, 1'b1, 32'h0000_0010, mem_word(32'h0000_000C)};
      vecs[4]  = '{1'b0, 1'b1, 32'h0,        1'b1, 32'h0000_0010, 1'b0, 32'h0000_0010, 32'h0000_0000};
      vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b1, 32'h0000_0004, mem_word(32'h0000_0000)};
      vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0004, 1'b1, 32'h0000_0008, mem_word(32'h0000_0004)};
      vecs[7]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0008, 1'b1, 32'h0000_0008, mem_word(32'h0000_0004)};
      vecs[8]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_0008, 1'b1, 32'h0000_0008, mem_word(32'h0000_0004)};
      vecs[9]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_0008, 1'b1, 32'h0000_0008, mem_word(32'h0000_0004)};
      vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0008, 1'b1, 32'h0000_000C, mem_word(32'h0000_0008)};
      vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_000C, 1'b1, 32'h0000_0010, mem_word(32'h0000_000C)};
      vecs[12] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0010, 1'b1, 32'h0000_0010, mem_word(32'h0000_000C)};
      vecs[13] = '{1'b1, 1'b1, 32'h200,      1'b0, 32'h0000_0010, 1'b0, 32'h0000_0010, 32'h0000_0000};
      vecs[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0200, 1'b1, 32'h0000_0204, mem_word(32'h0000_0200)};
      vecs[15] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0204, 1'b0, 32'h0000_0204, 32'h0000_0000};
      vecs[16] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0000, mem_word(32'hFFFF_FFFC)};
      vecs[17] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b1, 32'h0000_0004, mem_word(32'h0000_0000)};

      // Reset state.
      @(posedge clk);
      #1;
      check("reset valid", {31'd0, valid}, 32'd0);
      check("reset pc_out", pc_out, 32'h0000_0000);
      check("reset instruction", instruction, 32'h0000_0000);
      check("reset imem_req", {31'd0, imem_req}, 32'd0);
      rst = 1'b0;

      // Zero-wait sequence: throughput, freeze/stall, branch in stall, wrap.
      for (int i = 0; i < 18; i++) begin
         step(vecs[i].frz, vecs[i].br, vecs[i].baddr, vecs[i].exp_req, vecs[i].exp_addr,
              vecs[i].exp_valid, vecs[i].exp_pc, vecs[i].exp_instr, $sformatf("vec%0d", i));
      end

      // Redirect to 0x10 with zero-wait memory, then switch to latency 3.
      step(1'b0, 1'b1, 32'h10, 1'b1, 32'h0000_0004, 1'b0, 32'h0000_0004, 32'h0, "br10");
      lat = 3;
      step(1'b0, 1'b0, 32'h0,   1'b1, 32'h0000_0010, 1'b0, 32'h0000_0004, 32'h0, "lat_a");
      step(1'b0, 1'b1, 32'h100, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_0004, 32'h0, "lat_br");
      step(1'b0, 1'b0, 32'h0,   1'b1, 32'h0000_0010, 1'b0, 32'h0000_0004, 32'h0, "drain_c");
      step(1'b0, 1'b0, 32'h0,   1'b1, 32'h0000_0010, 1'b0, 32'h0000_0004, 32'h0, "drain_ack");
      step(1'b0, 1'b0, 32'h0,   1'b1, 32'h0000_0100, 1'b0, 32'h0000_0004, 32'h0, "tgt_e");
      step(1'b0, 1'b0, 32'h0,   1'b1, 32'h0000_0100, 1'b0, 32'h0000_0004, 32'h0, "tgt_f");
      step(1'b0, 1'b0, 32'h0,   1'b1, 32'h0000_0100, 1'b0, 32'h0000_0004, 32'h0, "tgt_g");
      step(1'b0, 1'b0, 32'h0,   1'b1, 32'h0000_0100, 1'b1, 32'h0000_0104, mem_word(32'h0000_0100), "tgt_ack");

      // Enter DRAIN, then reset asynchronously mid-request.
      step(1'b0, 1'b1, 32'h300, 1'b1, 32'h0000_0104, 1'b0, 32'h0000_0104, 32'h0, "br300");
      branch_taken = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_drain valid", {31'd0, valid}, 32'd0);
      check("rst_drain pc_out", pc_out, 32'h0000_0000);
      check("rst_drain instruction", instruction, 32'h0000_0000);
      check("rst_drain imem_req", {31'd0, imem_req}, 32'd0);
      @(posedge clk);
      #1;
      lat = 0;
      rst = 1'b0;
      step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0004, mem_word(32'h0000_0000), "post_rst0");
      step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0008, mem_word(32'h0000_0004), "post_rst1");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
